// File: rtl/ppi_pkg.sv
// Shared encodings for the PPI bus master: request ops, PPI port addresses,
// bus-cycle FSM states and the mode-word flag bit.
package ppi_pkg;

  typedef enum logic [1:0] {
    OP_WR   = 2'b00,
    OP_RD   = 2'b01,
    OP_CTRL = 2'b10,
    OP_BSR  = 2'b11
  } op_e;

  localparam logic [1:0] A_PA   = 2'b00;
  localparam logic [1:0] A_PB   = 2'b01;
  localparam logic [1:0] A_PC   = 2'b10;
  localparam logic [1:0] A_CTRL = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    TURN,
    RESP
  } state_e;

  localparam int unsigned CTRL_MODE_BIT = 7;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/ppi_cycle_timer.sv
// Loadable down-counter shared by all timed bus-cycle phases; done while zero.
module ppi_cycle_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/ppi_bus_master.sv
// Host-side initiator for the 8255-style PPI bus: one request -> one timed bus cycle.
// Define PPI_BSR_EN to execute BSR (op 11) requests; otherwise they are rejected.
module ppi_bus_master #(
  parameter int unsigned SETUP_CYC     = 1,
  parameter int unsigned STROBE_CYC    = 2,
  parameter int unsigned HOLD_CYC      = 1,
  parameter int unsigned TURN_CYC      = 1,
  parameter bit          STROBE_ACT_HI = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [1:0] req_port,
  input  logic [7:0] req_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [7:0] bus_d_out,
  output logic       bus_d_oe,
  input  logic [7:0] bus_d_in,
  output logic [1:0] bus_a,
  output logic       bus_cs,
  output logic       bus_rd,
  output logic       bus_wr
);
  import ppi_pkg::*;

  localparam int unsigned MAXC = max4(SETUP_CYC, STROBE_CYC, HOLD_CYC, TURN_CYC);
  localparam int unsigned CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] LD_SETUP  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] LD_STROBE = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] LD_HOLD   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] LD_TURN   = CW'(TURN_CYC - 1);

  state_e          state;
  op_e             op_q;
  op_e             req_op_e;
  logic            cs_q, rd_q, wr_q;
  logic [7:0]      rd_cap;
  logic            accept, bad, is_rd;
  logic [1:0]      acc_a;
  logic [7:0]      acc_d;
  logic            tmr_load, tmr_done;
  logic [CW-1:0]   tmr_val;

  assign req_op_e = op_e'(req_op);
  assign is_rd    = (op_q == OP_RD);
  assign accept   = (state == IDLE) && req_ready && req_valid;

  always_comb begin
    bad   = 1'b0;
    acc_a = A_CTRL;
    acc_d = '0;
    case (req_op_e)
      OP_WR: begin
        bad   = (req_port == A_CTRL);
        acc_a = req_port;
        acc_d = req_data;
      end
      OP_RD: begin
        bad   = (req_port == A_CTRL);
        acc_a = req_port;
      end
      OP_CTRL: begin
        bad   = !req_data[CTRL_MODE_BIT];
        acc_d = req_data;
      end
      default: begin
`ifdef PPI_BSR_EN
        acc_d = {4'b0000, req_data[3:0]};
`else
        bad   = 1'b1;
`endif
      end
    endcase
  end

  // Timer is reloaded on each timed-state entry so 'done' marks the phase's last cycle.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      IDLE:   if (accept && !bad) begin tmr_load = 1'b1; tmr_val = LD_SETUP;  end
      SETUP:  if (tmr_done)       begin tmr_load = 1'b1; tmr_val = LD_STROBE; end
      STROBE: if (tmr_done)       begin tmr_load = 1'b1; tmr_val = LD_HOLD;   end
      HOLD:   if (tmr_done && is_rd) begin tmr_load = 1'b1; tmr_val = LD_TURN; end
      default: ;
    endcase
  end

  ppi_cycle_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_q      <= OP_WR;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      cs_q      <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      bus_d_oe  <= 1'b0;
      bus_d_out <= '0;
      bus_a     <= '0;
      rd_cap    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            op_q      <= req_op_e;
            if (bad) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_data  <= '0;
            end else begin
              state     <= SETUP;
              cs_q      <= 1'b1;
              bus_a     <= acc_a;
              bus_d_out <= acc_d;
              bus_d_oe  <= (req_op_e != OP_RD);
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        SETUP: if (tmr_done) begin
          state <= STROBE;
          rd_q  <= is_rd;
          wr_q  <= !is_rd;
        end
        STROBE: if (tmr_done) begin
          state <= HOLD;
          rd_q  <= 1'b0;
          wr_q  <= 1'b0;
          if (is_rd) rd_cap <= bus_d_in;
        end
        HOLD: if (tmr_done) begin
          cs_q     <= 1'b0;
          bus_d_oe <= 1'b0;
          if (is_rd) begin
            state <= TURN;
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
          end
        end
        TURN: if (tmr_done) begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_data  <= rd_cap;
        end
        RESP: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus_cs = STROBE_ACT_HI ? cs_q : ~cs_q;
  assign bus_rd = STROBE_ACT_HI ? rd_q : ~rd_q;
  assign bus_wr = STROBE_ACT_HI ? wr_q : ~wr_q;

endmodule
